fft_frame_serializer: RTL and testbench

- Consumes the parallel N-point frame produced by fft_N_rad2 (fft_out array plus single-cycle out_valid) and re-emits it as a serial stream, one complex sample per accepted cycle, under a valid/ready handshake.
- Sits at the FFT output, mirroring the serial data_in side at the FFT input.
- Ping-pong double buffer: one frame streams out while the next is captured.
- Frames arriving when both banks are full are dropped and counted.

---
 rtl/fft_frame_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_fft_frame_serializer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_serializer.sv
// ---------------------------------------------------------------------------
// fft_frame_serializer
//
// Turns the parallel N-point frame produced by fft_N_rad2 back into a serial
// stream of complex samples, one per accepted cycle. A ping-pong pair of
// frame banks lets one frame stream out while the next one is captured.
// Frames that arrive while both banks are full are dropped and counted.
//
// Sample layout (complex_product_t flattened to a packed word):
//   sample[2*DATA_W-1:DATA_W] = real part (.r)
//   sample[DATA_W-1:0]        = imaginary part (.i)
//   frame_in entry k occupies frame_in[k*2*DATA_W +: 2*DATA_W].
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   frame_in     parallel FFT frame (connect to fft_out)
//   frame_valid  single-cycle frame strobe (connect to FFT out_valid)
//   frame_ready  write bank free: the next frame_valid will be captured
//   data_out     current serial sample ({r, i})
//   data_valid   data_out valid
//   data_ready   downstream accept
//   data_index   natural-order bin index of data_out
//   data_last    high with the final sample (index N-1) of a frame
//   drop_count   saturating count of dropped frames
//   busy         any bank full or streaming
//   state_dbg    output FSM state (0 = IDLE, 1 = STREAM)
//
// Build option:
//   FFT_SER_BITREV_EN  when defined, bank entries are read at the bit-reversed
//                      index, so a bit-reversed FFT frame is emitted in
//                      natural bin order; data_index still reports the
//                      natural index. Timing is identical in both builds.
//
// Handshake: a sample transfers on each rising edge where data_valid and
// data_ready are both high. Once data_valid is raised it stays high, and
// data_out/data_index/data_last stay stable, until that sample transfers.
// The upstream side has no backpressure: frame_valid is only a strobe and
// frame_ready is advisory.
// ---------------------------------------------------------------------------
module fft_frame_serializer #(
    parameter int N      = 128,
    parameter int CNT_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N*2*DATA_W-1:0]     frame_in,
    input  logic                      frame_valid,
    output logic                      frame_ready,
    output logic [2*DATA_W-1:0]       data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic [$clog2(N)-1:0]      data_index,
    output logic                      data_last,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      busy,
    output logic                      state_dbg
);

    localparam int                IDX_W    = $clog2(N);
    localparam int                SMP_W    = 2 * DATA_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [1:0][N*SMP_W-1:0] bank;
    logic [1:0]         bank_full, bank_full_nxt;
    logic               wr_bank, wr_bank_nxt;
    logic               rd_bank, rd_bank_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [IDX_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   drop_cnt, drop_cnt_nxt;
    logic               capture;
    logic [N*SMP_W-1:0] rd_frame;
    logic [SMP_W-1:0]   rd_word;

    // -----------------------------------------------------------------------
    // Read address within the read bank
    // -----------------------------------------------------------------------
`ifdef FFT_SER_BITREV_EN
    always_comb begin
        rd_addr = '0;
        for (int b = 0; b < IDX_W; b++) begin
            rd_addr[b] = idx[IDX_W-1-b];
        end
    end
`else
    assign rd_addr = idx;
`endif

    always_comb begin
        rd_frame = bank[rd_bank];
        rd_word  = rd_frame[int'(rd_addr)*SMP_W +: SMP_W];
    end

    // A frame is only written into an empty bank, so the bank being read is
    // never overwritten. The decision uses the registered bank_full, so a
    // bank released on this edge is not writable until the next cycle.
    assign capture     = frame_valid & ~bank_full[wr_bank];
    assign frame_ready = ~bank_full[wr_bank];

    // -----------------------------------------------------------------------
    // Next-state logic and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        bank_full_nxt = bank_full;
        wr_bank_nxt   = wr_bank;
        rd_bank_nxt   = rd_bank;
        drop_cnt_nxt  = drop_cnt;
        data_valid    = 1'b0;
        data_out      = '0;
        data_index    = '0;
        data_last     = 1'b0;

        // Capture side. Capture needs the write bank empty and release needs
        // the read bank full, so the two never touch the same bank on one edge.
        if (frame_valid) begin
            if (!bank_full[wr_bank]) begin
                bank_full_nxt[wr_bank] = 1'b1;
                wr_bank_nxt            = ~wr_bank;
            end else if (drop_cnt != CNT_MAX) begin
                drop_cnt_nxt = drop_cnt + CNT_W'(1);
            end
        end

        // Output side
        case (state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end
            end

            STREAM: begin
                data_valid = 1'b1;
                data_out   = rd_word;
                data_index = idx;
                data_last  = (idx == LAST_IDX);
                if (data_ready) begin
                    if (idx == LAST_IDX) begin
                        bank_full_nxt[rd_bank] = 1'b0;
                        rd_bank_nxt            = ~rd_bank;
                        idx_nxt                = '0;
                        // Continue straight into the other bank if it already
                        // holds a frame, so consecutive frames have no bubble.
                        state_nxt = bank_full[~rd_bank] ? STREAM : IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            bank_full <= bank_full_nxt;
            wr_bank   <= wr_bank_nxt;
            rd_bank   <= rd_bank_nxt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

    // Frame storage is not reset; bank_full alone says whether contents matter.
    always_ff @(posedge clk) begin
        if (capture) begin
            bank[wr_bank] <= frame_in;
        end
    end

    assign drop_count = drop_cnt;
    assign busy       = (state == STREAM) | (|bank_full);
    assign state_dbg  = state;

endmodule

// File: tb/tb_fft_frame_serializer.sv
// ---------------------------------------------------------------------------
// tb_fft_frame_serializer
//
// Directed bench for fft_frame_serializer. A 128-point instance covers reset,
// single frame, backpressure, back-to-back, overflow and mid-stream reset;
// an 8-point instance covers the read order (natural, or bit-reversed when
// FFT_SER_BITREV_EN is defined).
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
// ---------------------------------------------------------------------------
module tb_fft_frame_serializer;

    localparam int N   = 128;
    localparam int N8  = 8;
    localparam int W   = 16;
    localparam int SW  = 2 * W;
    localparam int TRL = 300;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 128-point instance
    logic [N*SW-1:0] frame_in;
    logic            frame_valid;
    logic            frame_ready;
    logic [SW-1:0]   data_out;
    logic            data_valid;
    logic            data_ready;
    logic [6:0]      data_index;
    logic            data_last;
    logic [7:0]      drop_count;
    logic            busy;
    logic            state_dbg;

    // 8-point instance
    logic [N8*SW-1:0] d8_frame_in;
    logic             d8_frame_valid;
    logic             d8_frame_ready;
    logic [SW-1:0]    d8_data_out;
    logic             d8_data_valid;
    logic             d8_data_ready;
    logic [2:0]       d8_data_index;
    logic             d8_data_last;
    logic [7:0]       d8_drop_count;
    logic             d8_busy;
    logic             d8_state_dbg;

    fft_frame_serializer #(.N(N), .CNT_W(8), .DATA_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .data_index  (data_index),
        .data_last   (data_last),
        .drop_count  (drop_count),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    fft_frame_serializer #(.N(N8), .CNT_W(8), .DATA_W(W)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (d8_frame_in),
        .frame_valid (d8_frame_valid),
        .frame_ready (d8_frame_ready),
        .data_out    (d8_data_out),
        .data_valid  (d8_data_valid),
        .data_ready  (d8_data_ready),
        .data_index  (d8_data_index),
        .data_last   (d8_data_last),
        .drop_count  (d8_drop_count),
        .busy        (d8_busy),
        .state_dbg   (d8_state_dbg)
    );

    // ---------------------------------------------------------------- bookkeeping
    int vectors     = 0;
    int miscompares = 0;

    logic [SW-1:0] exp_q[$];

    // per-cycle trace of the 128-point output
    logic          tr_valid [TRL];
    logic [SW-1:0] tr_data  [TRL];
    logic [6:0]    tr_idx   [TRL];
    logic          tr_last  [TRL];
    logic          tr_ready [TRL];
    logic          tr_fready[TRL];

    // frame entry j: r = base + j, i = -j
    function automatic logic [N*SW-1:0] make_frame(input int base);
        logic [N*SW-1:0] f;
        for (int j = 0; j < N; j++) begin
            f[j*SW +: SW] = {16'(base + j), 16'(-j)};
        end
        return f;
    endfunction

    // frame entry presented at natural output index k
    function automatic int exp_pos(input int k);
`ifdef FFT_SER_BITREV_EN
        logic [6:0] a;
        logic [6:0] b;
        a = 7'(k);
        for (int i = 0; i < 7; i++) b[i] = a[6-i];
        return int'(b);
`else
        return k;
`endif
    endfunction

    function automatic logic [SW-1:0] exp_sample(input int base, input int k);
        int j;
        j = exp_pos(k);
        return {16'(base + j), 16'(-j)};
    endfunction

    // ---------------------------------------------------------------- drivers
    // Presents one frame for one cycle; returns at the next falling edge.
    task automatic drive_frame(input int base);
        frame_in    = make_frame(base);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    // Records n cycles of output. mode 0: ready high, 1: ready 1,0,1,0...,
    // 2: ready low. Called at a falling edge; returns at a falling edge.
    task automatic run_cycles(input int n, input int mode);
        for (int t = 0; t < n; t++) begin
            case (mode)
                0:       data_ready = 1'b1;
                1:       data_ready = (t % 2 == 0);
                default: data_ready = 1'b0;
            endcase
            #1;
            tr_valid[t]  = data_valid;
            tr_data[t]   = data_out;
            tr_idx[t]    = data_index;
            tr_last[t]   = data_last;
            tr_ready[t]  = data_ready;
            tr_fready[t] = frame_ready;
            @(negedge clk);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset;
        reset          = 1'b0;
        frame_valid    = 1'b0;
        frame_in       = '0;
        data_ready     = 1'b0;
        d8_frame_valid = 1'b0;
        d8_frame_in    = '0;
        d8_data_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL por_data_valid got %b exp 0", data_valid); end
        vectors++; if (data_last !== 1'b0) begin miscompares++; $display("FAIL por_data_last got %b exp 0", data_last); end
        vectors++; if (data_index !== 7'd0) begin miscompares++; $display("FAIL por_data_index got %0d exp 0", data_index); end
        vectors++; if (data_out !== 32'd0) begin miscompares++; $display("FAIL por_data_out got %h exp 0", data_out); end
        vectors++; if (frame_ready !== 1'b1) begin miscompares++; $display("FAIL por_frame_ready got %b exp 1", frame_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL por_busy got %b exp 0", busy); end
        vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL por_drop_count got %0d exp 0", drop_count); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        data_ready = 1'b1;
        drive_frame(0);
        #1;
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL single_latency_c1 got %b exp 0", data_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_c1 got %b exp 1", busy); end
        @(negedge clk);
        run_cycles(140, 0);
        for (int t = 0; t < 140; t++) begin
            if (t < N) begin
                vectors++; if (tr_valid[t] !== 1'b1) begin miscompares++; $display("FAIL single_valid t=%0d got %b exp 1", t, tr_valid[t]); end
                vectors++; if (tr_data[t] !== exp_sample(0, t)) begin miscompares++; $display("FAIL single_data t=%0d got %h exp %h", t, tr_data[t], exp_sample(0, t)); end
                vectors++; if (tr_idx[t] !== 7'(t)) begin miscompares++; $display("FAIL single_index t=%0d got %0d exp %0d", t, tr_idx[t], t); end
                vectors++; if (tr_last[t] !== (t == N - 1)) begin miscompares++; $display("FAIL single_last t=%0d got %b exp %b", t, tr_last[t], (t == N - 1)); end
            end else begin
                vectors++; if (tr_valid[t] !== 1'b0) begin miscompares++; $display("FAIL single_tail_valid t=%0d got %b exp 0", t, tr_valid[t]); end
                vectors++; if (tr_data[t] !== 32'd0) begin miscompares++; $display("FAIL single_tail_data t=%0d got %h exp 0", t, tr_data[t]); end
                vectors++; if (tr_last[t] !== 1'b0) begin miscompares++; $display("FAIL single_tail_last t=%0d got %b exp 0", t, tr_last[t]); end
            end
        end
    endtask

    task automatic test_backpressure;
        int nxt;
        data_ready = 1'b1;
        drive_frame(0);
        @(negedge clk);
        run_cycles(TRL, 1);
        nxt = 0;
        for (int t = 0; t < TRL; t++) begin
            if (tr_valid[t] && tr_ready[t]) begin
                vectors++; if (tr_data[t] !== exp_sample(0, nxt)) begin miscompares++; $display("FAIL bp_data n=%0d got %h exp %h", nxt, tr_data[t], exp_sample(0, nxt)); end
                vectors++; if (tr_idx[t] !== 7'(nxt)) begin miscompares++; $display("FAIL bp_index n=%0d got %0d exp %0d", nxt, tr_idx[t], nxt); end
                nxt++;
            end else if (tr_valid[t] && !tr_ready[t] && t + 1 < TRL) begin
                vectors++; if (tr_valid[t+1] !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid t=%0d got %b exp 1", t, tr_valid[t+1]); end
                vectors++; if (tr_data[t+1] !== tr_data[t]) begin miscompares++; $display("FAIL bp_hold_data t=%0d got %h exp %h", t, tr_data[t+1], tr_data[t]); end
                vectors++; if (tr_idx[t+1] !== tr_idx[t]) begin miscompares++; $display("FAIL bp_hold_index t=%0d got %0d exp %0d", t, tr_idx[t+1], tr_idx[t]); end
                vectors++; if (tr_last[t+1] !== tr_last[t]) begin miscompares++; $display("FAIL bp_hold_last t=%0d got %b exp %b", t, tr_last[t+1], tr_last[t]); end
            end
        end
        vectors++; if (nxt !== N) begin miscompares++; $display("FAIL bp_transfer_count got %0d exp %0d", nxt, N); end
    endtask

    task automatic test_back_to_back;
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(exp_sample(0, k));
        for (int k = 0; k < N; k++) exp_q.push_back(exp_sample(1000, k));
        data_ready  = 1'b1;
        frame_in    = make_frame(0);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_in = make_frame(1000);
        @(negedge clk);
        frame_valid = 1'b0;
        run_cycles(270, 0);
        for (int t = 0; t < 270; t++) begin
            if (t < 2 * N) begin
                vectors++; if (tr_valid[t] !== 1'b1) begin miscompares++; $display("FAIL b2b_valid t=%0d got %b exp 1", t, tr_valid[t]); end
                if (exp_q.size() > 0) begin
                    logic [SW-1:0] e;
                    e = exp_q.pop_front();
                    vectors++; if (tr_data[t] !== e) begin miscompares++; $display("FAIL b2b_data t=%0d got %h exp %h", t, tr_data[t], e); end
                end
                vectors++; if (tr_idx[t] !== 7'(t % N)) begin miscompares++; $display("FAIL b2b_index t=%0d got %0d exp %0d", t, tr_idx[t], t % N); end
            end else begin
                vectors++; if (tr_valid[t] !== 1'b0) begin miscompares++; $display("FAIL b2b_tail_valid t=%0d got %b exp 0", t, tr_valid[t]); end
            end
            if (t <= N) begin
                vectors++; if (tr_fready[t] !== (t == N)) begin miscompares++; $display("FAIL b2b_frame_ready t=%0d got %b exp %b", t, tr_fready[t], (t == N)); end
            end
        end
    endtask

    task automatic test_overflow;
        int xfers;
        data_ready  = 1'b0;
        frame_in    = make_frame(0);
        frame_valid = 1'b1;
        @(negedge clk);
        frame_in = make_frame(1000);
        @(negedge clk);
        frame_in = make_frame(2000);
        @(negedge clk);
        frame_valid = 1'b0;
        #1;
        vectors++; if (drop_count !== 8'd1) begin miscompares++; $display("FAIL ovf_drop_1 got %0d exp 1", drop_count); end
        vectors++; if (frame_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_frame_ready got %b exp 0", frame_ready); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovf_busy got %b exp 1", busy); end
        vectors++; if (data_out !== exp_sample(0, 0)) begin miscompares++; $display("FAIL ovf_held_data got %h exp %h", data_out, exp_sample(0, 0)); end
        frame_in    = make_frame(3000);
        frame_valid = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        vectors++; if (drop_count !== 8'd101) begin miscompares++; $display("FAIL ovf_drop_101 got %0d exp 101", drop_count); end
        repeat (154) @(negedge clk);
        #1;
        vectors++; if (drop_count !== 8'd255) begin miscompares++; $display("FAIL ovf_drop_255 got %0d exp 255", drop_count); end
        repeat (46) @(negedge clk);
        frame_valid = 1'b0;
        #1;
        vectors++; if (drop_count !== 8'd255) begin miscompares++; $display("FAIL ovf_drop_sat got %0d exp 255", drop_count); end
        exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(exp_sample(0, k));
        for (int k = 0; k < N; k++) exp_q.push_back(exp_sample(1000, k));
        run_cycles(270, 0);
        xfers = 0;
        for (int t = 0; t < 270; t++) begin
            if (tr_valid[t] && tr_ready[t]) begin
                xfers++;
                if (exp_q.size() > 0) begin
                    logic [SW-1:0] e;
                    e = exp_q.pop_front();
                    vectors++; if (tr_data[t] !== e) begin miscompares++; $display("FAIL ovf_data t=%0d got %h exp %h", t, tr_data[t], e); end
                end
            end
        end
        vectors++; if (xfers !== 2 * N) begin miscompares++; $display("FAIL ovf_transfer_count got %0d exp %0d", xfers, 2 * N); end
    endtask

    task automatic test_reset_midstream;
        int guard;
        data_ready = 1'b1;
        drive_frame(0);
        #1;
        guard = 0;
        while (!(data_valid === 1'b1 && data_index === 7'd40) && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        vectors++; if (guard >= 200) begin miscompares++; $display("FAIL rst_reach_idx40 got timeout exp index 40"); end
        // assert reset between edges and check without any clock edge
        reset = 1'b0;
        #1;
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL rst_async_valid got %b exp 0", data_valid); end
        vectors++; if (data_out !== 32'd0) begin miscompares++; $display("FAIL rst_async_data got %h exp 0", data_out); end
        vectors++; if (data_index !== 7'd0) begin miscompares++; $display("FAIL rst_async_index got %0d exp 0", data_index); end
        vectors++; if (frame_ready !== 1'b1) begin miscompares++; $display("FAIL rst_async_frame_ready got %b exp 1", frame_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_async_busy got %b exp 0", busy); end
        vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL rst_async_drop got %0d exp 0", drop_count); end
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL rst_residual_valid t=%0d got %b exp 0", t, data_valid); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_residual_busy t=%0d got %b exp 0", t, busy); end
        end
    endtask

    task automatic test_n8_order;
        int exp8[8];
`ifdef FFT_SER_BITREV_EN
        exp8 = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        exp8 = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        for (int j = 0; j < N8; j++) d8_frame_in[j*SW +: SW] = {16'(j), 16'(-j)};
        d8_data_ready  = 1'b1;
        d8_frame_valid = 1'b1;
        @(negedge clk);
        d8_frame_valid = 1'b0;
        @(negedge clk);
        for (int t = 0; t < N8; t++) begin
            #1;
            vectors++; if (d8_data_valid !== 1'b1) begin miscompares++; $display("FAIL n8_valid t=%0d got %b exp 1", t, d8_data_valid); end
            vectors++; if (d8_data_out[SW-1:W] !== 16'(exp8[t])) begin miscompares++; $display("FAIL n8_real t=%0d got %0d exp %0d", t, d8_data_out[SW-1:W], exp8[t]); end
            vectors++; if (d8_data_index !== 3'(t)) begin miscompares++; $display("FAIL n8_index t=%0d got %0d exp %0d", t, d8_data_index, t); end
            vectors++; if (d8_data_last !== (t == N8 - 1)) begin miscompares++; $display("FAIL n8_last t=%0d got %b exp %b", t, d8_data_last, (t == N8 - 1)); end
            @(negedge clk);
        end
        #1;
        vectors++; if (d8_data_valid !== 1'b0) begin miscompares++; $display("FAIL n8_tail_valid got %b exp 0", d8_data_valid); end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_midstream();
        test_n8_order();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
